// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
// The producer offers tx_data with tx_valid, and the transmitter answers with tx_ready.
interface uart_tx_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, CLKS_PER_BIT clocks per bit.
// A one-byte holding register lets frames go out back to back with no idle gap.
module uart_tx #(
    parameter int CLKS_PER_BIT = 521
) (
    input  logic     tx_clk,
    input  logic     rst_n,
    uart_tx_if.slave tx_bus,
    output logic     tx_out,
    output logic     tx_busy,
    output logic     tx_done
);
    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] DONE_CNT = 16'(CLKS_PER_BIT - 2);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state_reg;
    logic [15:0] cnt_reg;
    logic [2:0]  bit_idx_reg;
    logic [7:0]  shift_reg;
    logic [7:0]  hold_reg;
    logic        hold_full_reg;
    logic        tx_out_reg;
    logic        busy_reg;
    logic        done_reg;

    logic accept;
    logic bit_end;
    logic free_edge;

    assign tx_bus.tx_ready = ~hold_full_reg;
    assign accept          = tx_bus.tx_valid & ~hold_full_reg;
    assign bit_end         = (cnt_reg == LAST_CNT);
    // The shifter can take a new byte in IDLE or on the final stop cycle.
    assign free_edge       = (state_reg == IDLE) || ((state_reg == STOP) && bit_end);

    assign tx_out  = tx_out_reg;
    assign tx_busy = busy_reg;
    assign tx_done = done_reg;

    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            bit_idx_reg   <= '0;
            shift_reg     <= '0;
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
            tx_out_reg    <= 1'b1;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            // Register the pulse one edge early so it lands on the last stop cycle.
            done_reg <= (state_reg == STOP) && (cnt_reg == DONE_CNT);

            if (free_edge) begin
                cnt_reg     <= '0;
                bit_idx_reg <= '0;
                if (hold_full_reg) begin
                    shift_reg     <= hold_reg;
                    hold_full_reg <= 1'b0;
                    state_reg     <= START;
                    tx_out_reg    <= 1'b0;
                    busy_reg      <= 1'b1;
                end else if (accept) begin
                    shift_reg  <= tx_bus.tx_data;
                    state_reg  <= START;
                    tx_out_reg <= 1'b0;
                    busy_reg   <= 1'b1;
                end else begin
                    state_reg  <= IDLE;
                    tx_out_reg <= 1'b1;
                    busy_reg   <= 1'b0;
                end
            end else begin
                if (accept) begin
                    hold_reg      <= tx_bus.tx_data;
                    hold_full_reg <= 1'b1;
                end
                if (bit_end) begin
                    cnt_reg <= '0;
                    case (state_reg)
                        START: begin
                            state_reg   <= DATA;
                            bit_idx_reg <= '0;
                            tx_out_reg  <= shift_reg[0];
                        end
                        DATA: begin
                            if (bit_idx_reg == 3'd7) begin
                                state_reg  <= STOP;
                                tx_out_reg <= 1'b1;
                            end else begin
                                bit_idx_reg <= bit_idx_reg + 3'd1;
                                tx_out_reg  <= shift_reg[bit_idx_reg + 3'd1];
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end
        end
    end
endmodule
